imm_gen_pipe: RTL

Parametrised, pipelined successor to the combinational immediate generator. It sits in the decode stage between the fetch buffer and the register-read/execute stage. Each instruction is registered behind a valid/ready handshake with a 2-entry skid buffer, and the unit produces the sign-extended immediate at XLEN width together with an immediate-format code, an unknown-opcode flag and a pass-through tag. New relative to the old block: RV64 support, CSR zimm format, format/illegal reporting, flush, and full-throughput backpressure.

---
 rtl/imm_pkg.sv | 29 ++
 rtl/imm_decode.sv | 71 +++++++
 rtl/imm_gen_pipe.sv | 112 +++++++++++
 3 files changed

// File: rtl/imm_pkg.sv
// Shared opcode and immediate-format definitions for the decode-stage
// immediate generator and its future compressed-expansion sibling.
package imm_pkg;

  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_FENCE    = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6
  } imm_type_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: raw 32-bit instruction in, XLEN-wide
// immediate, format code and unknown-opcode flag out.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm,
  output imm_type_e       o_type,
  output logic            o_illegal
);

  logic [6:0]  w_opc;
  logic [31:0] w_imm32;

  assign w_opc = i_instr[6:0];

  always_comb begin
    w_imm32   = '0;
    o_type    = IMM_NONE;
    o_illegal = 1'b0;
    case (w_opc)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
        o_type  = IMM_I;
      end
      OPC_OP_IMM32: begin
        if (XLEN == 64) begin
          w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
          o_type  = IMM_I;
        end else begin
          o_illegal = 1'b1;
        end
      end
      OPC_STORE: begin
        w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
        o_type  = IMM_S;
      end
      OPC_BRANCH: begin
        w_imm32 = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
        o_type  = IMM_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        w_imm32 = {i_instr[31:12], 12'b0};
        o_type  = IMM_U;
      end
      OPC_JAL: begin
        w_imm32 = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
        o_type  = IMM_J;
      end
      OPC_SYSTEM: begin
        // funct3[2] selects the immediate CSR forms; zimm is unsigned
        if (i_instr[14]) begin
          w_imm32 = {27'b0, i_instr[19:15]};
          o_type  = IMM_Z;
        end
      end
      OPC_OP, OPC_FENCE: ;
      OPC_OP32: o_illegal = (XLEN != 64);
      default:  o_illegal = 1'b1;
    endcase
  end

  // Z leaves bit 31 clear, so a uniform sign-extension is safe for all formats
  always_comb begin
    o_imm       = {XLEN{w_imm32[31]}};
    o_imm[31:0] = w_imm32;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: combinational decode registered behind a
// valid/ready handshake with a two-entry (output + skid) buffer.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic [2:0]       imm_type,
  output logic             imm_illegal,
  output logic [TAG_W-1:0] tag_out
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  logic [XLEN-1:0]  w_imm;
  imm_type_e        w_type;
  logic             w_ill;
  logic             w_in_xfer;
  logic             w_out_free;

  logic             r_in_ready;
  logic             r_out_valid;
  logic [XLEN-1:0]  r_out_imm;
  logic [2:0]       r_out_type;
  logic             r_out_ill;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_skid_valid;
  logic [XLEN-1:0]  r_skid_imm;
  logic [2:0]       r_skid_type;
  logic             r_skid_ill;
  logic [TAG_W-1:0] r_skid_tag;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .i_instr   (instr_in),
    .o_imm     (w_imm),
    .o_type    (w_type),
    .o_illegal (w_ill)
  );

  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_free = ~r_out_valid | out_ready;

  // r_in_ready always mirrors ~r_skid_valid, kept as its own flop so the
  // upstream ready path starts at a register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_imm    <= '0;
      r_out_type   <= '0;
      r_out_ill    <= 1'b0;
      r_out_tag    <= '0;
      r_skid_valid <= 1'b0;
      r_skid_imm   <= '0;
      r_skid_type  <= '0;
      r_skid_ill   <= 1'b0;
      r_skid_tag   <= '0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_imm    <= r_skid_imm;
        r_out_type   <= r_skid_type;
        r_out_ill    <= r_skid_ill;
        r_out_tag    <= r_skid_tag;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end else begin
        r_out_valid <= w_in_xfer;
        if (w_in_xfer) begin
          r_out_imm  <= w_imm;
          r_out_type <= w_type;
          r_out_ill  <= w_ill;
          r_out_tag  <= tag_in;
        end
      end
    end else if (w_in_xfer) begin
      r_skid_valid <= 1'b1;
      r_skid_imm   <= w_imm;
      r_skid_type  <= w_type;
      r_skid_ill   <= w_ill;
      r_skid_tag   <= tag_in;
      r_in_ready   <= 1'b0;
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign imm_out     = r_out_imm;
  assign imm_type    = r_out_type;
  assign imm_illegal = r_out_ill;
  assign tag_out     = r_out_tag;

endmodule
